fifo_burst_drain: RTL and testbench



---
 rtl/fifo_burst_drain_pkg.sv | 19 +
 rtl/fifo_burst_drain_out_reg.sv | 41 ++++
 rtl/fifo_burst_drain.sv | 123 ++++++++++++
 tb/tb_fifo_burst_drain.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_drain_pkg.sv
// Shared types and defaults for the FIFO burst drainer: state encoding,
// default burst/timeout sizes and the length-tag width helper.
package fifo_burst_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_BURST_LEN = 16;
  localparam int DEF_TIMEOUT   = 64;

  // One extra bit so the tag can hold the full burst length itself.
  function automatic int len_width(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/fifo_burst_drain_out_reg.sv
// Single-entry valid/ready output register carrying one beat with its
// burst framing {data, first, last, len}; loads on pop, clears on accept.
module burst_out_reg #(
  parameter int DATA_W = 128,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_first,
  input  logic              load_last,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              first,
  output logic              last,
  output logic [LEN_W-1:0]  len
);

  // A load in the same cycle as an accept simply replaces the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      first <= 1'b0;
      last  <= 1'b0;
      len   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      first <= load_first;
      last  <= load_last;
      len   <= load_len;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_burst_drain.sv
// Drains a FWFT FIFO as fixed-length framed bursts onto a valid/ready stream.
// Define FIFO_BURST_DRAIN_TIMEOUT_EN to force partial bursts after idle residue.
module fifo_burst_drain
  import fifo_burst_drain_pkg::*;
#(
  parameter int C_DATA_WIDTH = 128,
  parameter int C_BURST_LEN  = DEF_BURST_LEN,
  parameter int C_TIMEOUT    = DEF_TIMEOUT,
  parameter int C_LEN_W      = len_width(C_BURST_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [C_DATA_WIDTH-1:0] fifo_dataout,
  input  logic                    fifo_empty,
  input  logic [17:0]             fifo_count,
  output logic                    fifo_rden,
  input  logic                    flush,
  output logic [C_DATA_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_first,
  output logic                    m_last,
  output logic [C_LEN_W-1:0]      m_len,
  output logic                    busy
);

  localparam logic [17:0]        BURST_LEN_CNT = 18'(C_BURST_LEN);
  localparam logic [C_LEN_W-1:0] BURST_LEN_TAG = C_LEN_W'(C_BURST_LEN);

  state_t             state, state_next;
  logic [C_LEN_W-1:0] beats_left, burst_len, start_len;
  logic               start, pop, timeout_hit, full_ready, flush_ready;

  assign full_ready  = fifo_count >= BURST_LEN_CNT;
  assign flush_ready = flush && (fifo_count != 18'd0);
  assign pop         = (state == BURST) && (beats_left != '0) && !fifo_empty &&
                       (!m_valid || m_ready);
  assign fifo_rden   = pop;
  assign busy        = state != IDLE;

`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
  localparam int TO_W = $clog2(C_TIMEOUT) + 1;

  logic [TO_W-1:0] idle_cnt;
  logic            idle_arm;

  assign idle_arm    = (state == IDLE) && (fifo_count != 18'd0) &&
                       (fifo_count < BURST_LEN_CNT) && !flush;
  assign timeout_hit = idle_arm && (idle_cnt == TO_W'(C_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || !idle_arm || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Below-full starts imply fifo_count < C_BURST_LEN, so its low bits are the exact length.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    start_len  = '0;
    case (state)
      IDLE: begin
        if (full_ready) begin
          start     = 1'b1;
          start_len = BURST_LEN_TAG;
        end else if (flush_ready || timeout_hit) begin
          start     = 1'b1;
          start_len = fifo_count[C_LEN_W-1:0];
        end
        if (start) state_next = BURST;
      end
      BURST: begin
        if (pop && (beats_left == C_LEN_W'(1))) state_next = DONE;
      end
      DONE: begin
        if (m_valid && m_ready && m_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beats_left <= '0;
      burst_len  <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        beats_left <= start_len;
        burst_len  <= start_len;
      end else if (pop) begin
        beats_left <= beats_left - 1'b1;
      end
    end
  end

  burst_out_reg #(
    .DATA_W (C_DATA_WIDTH),
    .LEN_W  (C_LEN_W)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (pop),
    .load_data  (fifo_dataout),
    .load_first (beats_left == burst_len),
    .load_last  (beats_left == C_LEN_W'(1)),
    .load_len   (burst_len),
    .ready      (m_ready),
    .valid      (m_valid),
    .data       (m_data),
    .first      (m_first),
    .last       (m_last),
    .len        (m_len)
  );

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Directed bench for fifo_burst_drain: a FWFT FIFO model feeds the DUT and a
// monitor collects accepted beats for comparison against the written sequence.
module tb_fifo_burst_drain;

  typedef struct {
    logic [127:0] data;
    logic         first;
    logic         last;
    logic [4:0]   len;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] fifo_dataout;
  logic         fifo_empty;
  logic [17:0]  fifo_count;
  logic         fifo_rden;
  logic         flush = 1'b0;
  logic [127:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic         m_first;
  logic         m_last;
  logic [4:0]   m_len;
  logic         busy;

  logic         wr_en = 1'b0;
  logic [127:0] wr_data = '0;
  logic         glitch = 1'b0;
  logic         rand_ready = 1'b0;
  logic         empty_hold;
  logic [127:0] mem [0:255];
  int           wp, rp, bad_pop;
  int           next_wr = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  beat_t        rx_q [$];
  beat_t        mon_b;

  fifo_burst_drain dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_dataout (fifo_dataout),
    .fifo_empty   (fifo_empty),
    .fifo_count   (fifo_count),
    .fifo_rden    (fifo_rden),
    .flush        (flush),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_first      (m_first),
    .m_last       (m_last),
    .m_len        (m_len),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // FWFT FIFO model: count updates on write, data becomes visible one cycle later.
  assign fifo_count   = 18'(wp - rp);
  assign fifo_empty   = (wp == rp) || empty_hold || glitch;
  assign fifo_dataout = mem[rp & 255];

  always @(posedge clk) begin
    if (rst) begin
      wp         <= 0;
      rp         <= 0;
      empty_hold <= 1'b0;
      bad_pop    <= 0;
    end else begin
      if (wr_en) begin
        mem[wp & 255] <= wr_data;
        wp            <= wp + 1;
      end
      if (fifo_rden) begin
        if (fifo_empty) bad_pop <= bad_pop + 1;
        else            rp      <= rp + 1;
      end
      empty_hold <= wr_en && (wp == rp);
    end
  end

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      mon_b.data  = m_data;
      mon_b.first = m_first;
      mon_b.last  = m_last;
      mon_b.len   = m_len;
      rx_q.push_back(mon_b);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  end

  function automatic logic [127:0] beat_val(input int s);
    return {32'hC0FFEE00, 32'(s), 32'hDEAD0000 + 32'(s), ~32'(s)};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_data = beat_val(next_wr);
      next_wr++;
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic waitBeats(input string tag, input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    checkOutput(tag, 128'(rx_q.size() >= n), 128'(1));
  endtask

  task automatic verifyBurst(input string tag, input int base, input int off, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      if (off + i < rx_q.size()) begin
        b = rx_q[off + i];
        checkOutput($sformatf("%s_b%0d_data", tag, i), b.data, beat_val(base + i));
        checkOutput($sformatf("%s_b%0d_first", tag, i), 128'(b.first), 128'(i == 0));
        checkOutput($sformatf("%s_b%0d_last", tag, i), 128'(b.last), 128'(i == n - 1));
        checkOutput($sformatf("%s_b%0d_len", tag, i), 128'(b.len), 128'(n));
      end
    end
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int d;
    logic seen;

    $display("[TB] reset values");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rden", 128'(fifo_rden), 128'(0));
    checkOutput("rst_valid", 128'(m_valid), 128'(0));
    checkOutput("rst_first", 128'(m_first), 128'(0));
    checkOutput("rst_last", 128'(m_last), 128'(0));
    checkOutput("rst_len", 128'(m_len), 128'(0));
    checkOutput("rst_data", m_data, 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] full burst of 16 with ready held high");
    base = next_wr;
    applyStimulus(16);
    @(negedge clk);
    checkOutput("lat_n_rden", 128'(fifo_rden), 128'(0));
    @(negedge clk);
    checkOutput("lat_n1_rden", 128'(fifo_rden), 128'(1));
    checkOutput("lat_n1_busy", 128'(busy), 128'(1));
    @(negedge clk);
    checkOutput("lat_n2_valid", 128'(m_valid), 128'(1));
    waitBeats("t1_got16", 16, 100);
    @(negedge clk);
    checkOutput("t1_busy_after", 128'(busy), 128'(0));
    checkOutput("t1_count", 128'(rx_q.size()), 128'(16));
    verifyBurst("t1", base, 0, 16);
    rx_q.delete();

    $display("[TB] 40 beats with random ready");
    rand_ready = 1'b1;
    base = next_wr;
    applyStimulus(40);
    waitBeats("t2_got32", 32, 400);
    repeat (4) @(negedge clk);
    rand_ready = 1'b0;
    m_ready = 1'b1;
    checkOutput("t2_count", 128'(rx_q.size()), 128'(32));
    checkOutput("t2_residue", 128'(fifo_count), 128'(8));
    checkOutput("t2_busy", 128'(busy), 128'(0));
    verifyBurst("t2a", base, 0, 16);
    verifyBurst("t2b", base + 16, 16, 16);
    rx_q.delete();

    $display("[TB] flush residue, then 5 beats and flush");
    base = base + 32;
    flush = 1'b1;
    waitBeats("t3_got8", 8, 100);
    @(negedge clk);
    flush = 1'b0;
    checkOutput("t3_count8", 128'(rx_q.size()), 128'(8));
    verifyBurst("t3a", base, 0, 8);
    rx_q.delete();
    base = next_wr;
    applyStimulus(5);
    flush = 1'b1;
    waitBeats("t3_got5", 5, 100);
    @(negedge clk);
    flush = 1'b0;
    checkOutput("t3_empty", 128'(fifo_empty), 128'(1));
    checkOutput("t3_fifo_count", 128'(fifo_count), 128'(0));
    checkOutput("t3_busy", 128'(busy), 128'(0));
    verifyBurst("t3b", base, 0, 5);
    rx_q.delete();

    $display("[TB] single write into empty FIFO under flush");
    flush = 1'b1;
    base = next_wr;
    applyStimulus(1);
    waitBeats("t4_got1", 1, 20);
    @(negedge clk);
    flush = 1'b0;
    verifyBurst("t4a", base, 0, 1);
    rx_q.delete();

    $display("[TB] empty flag stall mid-burst");
    base = next_wr;
    applyStimulus(16);
    waitBeats("t4_got4", 4, 100);
    @(posedge clk); #1;
    glitch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t4_stall_rden%0d", i), 128'(fifo_rden), 128'(0));
    end
    @(posedge clk); #1;
    glitch = 1'b0;
    waitBeats("t4_got16", 16, 100);
    @(negedge clk);
    checkOutput("t4_count", 128'(rx_q.size()), 128'(16));
    checkOutput("t4_no_pop_empty", 128'(bad_pop), 128'(0));
    verifyBurst("t4b", base, 0, 16);
    rx_q.delete();

    $display("[TB] reset on beat 7 of 16");
    applyStimulus(16);
    waitBeats("t5_got7", 7, 100);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_valid", 128'(m_valid), 128'(0));
    checkOutput("t5_busy", 128'(busy), 128'(0));
    checkOutput("t5_rden", 128'(fifo_rden), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    rx_q.delete();
    base = next_wr;
    applyStimulus(16);
    waitBeats("t5_got16", 16, 100);
    @(negedge clk);
    checkOutput("t5_busy_after", 128'(busy), 128'(0));
    checkOutput("t5_count", 128'(rx_q.size()), 128'(16));
    verifyBurst("t5", base, 0, 16);
    rx_q.delete();

    $display("[TB] idle residue of 3 beats");
    base = next_wr;
    applyStimulus(3);
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
    d = 0;
    seen = 1'b0;
    while (!seen && d < 200) begin
      @(negedge clk);
      d++;
      seen = busy;
    end
    checkOutput("t6_start_window", 128'(d >= 62 && d <= 66), 128'(1));
    waitBeats("t6_got3", 3, 50);
    verifyBurst("t6", base, 0, 3);
`else
    seen = 1'b0;
    d = 0;
    repeat (1000) begin
      @(negedge clk);
      seen = seen | busy | m_valid;
      d++;
    end
    checkOutput("t6_no_burst", 128'(seen), 128'(0));
    checkOutput("t6_residue", 128'(fifo_count), 128'(3));
    checkOutput("t6_rx_none", 128'(rx_q.size()), 128'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
